// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and helpers for the four-digit BCD scan counter.
package bcd_scan_counter_pkg;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         NUM_DIGITS     = 4;
  localparam logic [3:0] DIGIT_SEL_IDLE = 4'b1111;
  localparam int         IDX_W          = 2;

  typedef logic [IDX_W-1:0] scan_idx_t;

  // Active-low one-hot select for the digit addressed by idx.
  function automatic logic [3:0] digit_sel_of(input scan_idx_t idx);
    return DIGIT_SEL_IDLE & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One cascadable decade counter stage; co/bo flag a wrap and drive the next stage.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       co,
  output logic       bo
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == 4'd0 || digit_q > BCD_MAX) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // A clear suppresses any wrap so nothing ripples into the next stage.
  assign co    = inc & ~clr & (digit_q >= BCD_MAX);
  assign bo    = dec & ~inc & ~clr & (digit_q == 4'd0);
  assign digit = digit_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a time-multiplexed digit scanner feeding one decoder.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int CLK_DIV_COUNT = 50000000,
  parameter int SCAN_DIV      = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_sel,
  output logic        carry
);

  localparam int CNT_W  = (CLK_DIV_COUNT > 1) ? $clog2(CLK_DIV_COUNT) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV_COUNT - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  scan_idx_t         idx_q, idx_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        bcd_q, bcd_d;
  logic              carry_q, carry_d;
  logic              tick;
  logic              scan_tc;

  logic [NUM_DIGITS:0] inc_c;
  logic [NUM_DIGITS:0] dec_c;
  logic [3:0]          digits [NUM_DIGITS];

  assign tick     = en & (cnt_q == CNT_LAST);
  assign inc_c[0] = tick & up_dn;
  assign dec_c[0] = tick & ~up_dn;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_c[g]),
      .dec   (dec_c[g]),
      .clr   (clr),
      .digit (value[4*g +: 4]),
      .co    (inc_c[g+1]),
      .bo    (dec_c[g+1])
    );
    assign digits[g] = value[4*g +: 4];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign carry_d = (inc_c[NUM_DIGITS] | dec_c[NUM_DIGITS]) & ~clr;

  // Select and nibble are both derived from the next index so they move together.
  always_comb begin
    scan_tc    = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = scan_tc ? idx_q + scan_idx_t'(1) : idx_q;
    sel_d      = digit_sel_of(idx_d);
    bcd_d      = digits[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      sel_q      <= digit_sel_of('0);
      bcd_q      <= 4'd0;
      carry_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      bcd_q      <= bcd_d;
      carry_q    <= carry_d;
    end
  end

  assign digit_sel = sel_q;
  assign bcd_out   = bcd_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: two configurations driven in lockstep against an integer reference model.
module tb_bcd_scan_counter;

  localparam int DIV_A  = 1;
  localparam int SCAN_A = 4;
  localparam int DIV_B  = 3;
  localparam int SCAN_B = 3;

  logic clk;
  logic rst_n;
  logic en;
  logic up_dn;
  logic clr;

  logic [15:0] value_a, value_b;
  logic [3:0]  bcd_a, bcd_b;
  logic [3:0]  sel_a, sel_b;
  logic        carry_a, carry_b;

  int total = 0;
  int bad   = 0;

  // Reference model state per instance: value as a plain integer 0..9999.
  int m_val   [2];
  int m_prev  [2];
  int m_pre   [2];
  int m_k     [2];
  bit m_carry [2];
  int div_n   [2] = '{DIV_A, DIV_B};
  int scan_n  [2] = '{SCAN_A, SCAN_B};

  bcd_scan_counter #(.CLK_DIV_COUNT(DIV_A), .SCAN_DIV(SCAN_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
    .value(value_a), .bcd_out(bcd_a), .digit_sel(sel_a), .carry(carry_a)
  );

  bcd_scan_counter #(.CLK_DIV_COUNT(DIV_B), .SCAN_DIV(SCAN_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
    .value(value_b), .bcd_out(bcd_b), .digit_sel(sel_b), .carry(carry_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] digit_of(input int v, input int slot);
    logic [15:0] b;
    b = to_bcd(v);
    return b[4*slot +: 4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_prev[i] = 0; m_pre[i] = 0; m_k[i] = 0; m_carry[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_prev[i]  = m_val[i];
      m_carry[i] = 1'b0;
      if (clr) begin
        m_val[i] = 0;
        m_pre[i] = 0;
      end else if (en) begin
        if (m_pre[i] == div_n[i] - 1) begin
          m_pre[i] = 0;
          if (up_dn) begin
            m_carry[i] = (m_val[i] == 9999);
            m_val[i]   = (m_val[i] + 1) % 10000;
          end else begin
            m_carry[i] = (m_val[i] == 0);
            m_val[i]   = (m_val[i] + 9999) % 10000;
          end
        end else begin
          m_pre[i]++;
        end
      end
      m_k[i]++;
    end
  endtask

  task automatic check_all();
    logic [15:0] gv;
    logic [3:0]  gs, gb, es, eb;
    logic        gc;
    int          slot;
    string       sfx;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        gv = value_a; gs = sel_a; gb = bcd_a; gc = carry_a; sfx = "a";
      end else begin
        gv = value_b; gs = sel_b; gb = bcd_b; gc = carry_b; sfx = "b";
      end
      slot = (m_k[i] / scan_n[i]) % 4;
      es = 4'b1111;
      es[slot] = 1'b0;
      eb = (m_k[i] == 0) ? 4'h0 : digit_of(m_prev[i], slot);
      check({"value_", sfx}, gv, to_bcd(m_val[i]));
      check({"sel_", sfx}, {12'h0, gs}, {12'h0, es});
      check({"bcd_", sfx}, {12'h0, gb}, {12'h0, eb});
      check({"carry_", sfx}, {15'h0, gc}, {15'h0, m_carry[i]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n, input bit e, input bit u, input bit c);
    en = e; up_dn = u; clr = c;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value_a"}, value_a, 16'h0000);
    check({tag, "_sel_a"}, {12'h0, sel_a}, 16'h000e);
    check({tag, "_bcd_a"}, {12'h0, bcd_a}, 16'h0000);
    check({tag, "_carry_a"}, {15'h0, carry_a}, 16'h0000);
    check({tag, "_value_b"}, value_b, 16'h0000);
    check({tag, "_sel_b"}, {12'h0, sel_b}, 16'h000e);
    check({tag, "_carry_b"}, {15'h0, carry_b}, 16'h0000);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    check_all();

    // Up counting from zero.
    run(10, 1'b1, 1'b1, 1'b0);
    check("up10", value_a, 16'h0010);
    run(99, 1'b1, 1'b1, 1'b0);
    check("up109", value_a, 16'h0109);
    run(418, 1'b1, 1'b1, 1'b0);
    check("at0527", value_a, 16'h0527);
    mid_reset("mid");

    // Wrap in both directions.
    run(1, 1'b1, 1'b0, 1'b0);
    check("down_wrap", value_a, 16'h9999);
    check("down_carry", {15'h0, carry_a}, 16'h0001);
    run(1, 1'b0, 1'b0, 1'b0);
    check("down_carry_off", {15'h0, carry_a}, 16'h0000);
    run(1, 1'b1, 1'b1, 1'b0);
    check("up_wrap", value_a, 16'h0000);
    check("up_carry", {15'h0, carry_a}, 16'h0001);
    run(1, 1'b0, 1'b1, 1'b0);
    check("up_carry_off", {15'h0, carry_a}, 16'h0000);

    // Clear coincident with a wrapping tick, then hold.
    run(1, 1'b1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b1, 1'b1);
    check("clr_wrap_val", value_a, 16'h0000);
    check("clr_wrap_carry", {15'h0, carry_a}, 16'h0000);
    run(20, 1'b0, 1'b1, 1'b0);
    check("hold_val", value_a, 16'h0000);

    // Scan a held 1234.
    run(1234, 1'b1, 1'b1, 1'b0);
    check("at1234", value_a, 16'h1234);
    run(40, 1'b0, 1'b1, 1'b0);

    // Direction toggled on every tick from 0005.
    run(1, 1'b0, 1'b1, 1'b1);
    run(5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run(1, 1'b1, (i % 2 == 0), 1'b0);
      check("toggle", value_a, (i % 2 == 0) ? 16'h0006 : 16'h0005);
    end

    // Random traffic near the top of the range.
    run(1, 1'b0, 1'b1, 1'b1);
    run(5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      run(1, ($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1,
          ($urandom_range(59, 0) == 0));
      if ($urandom_range(499, 0) == 0) mid_reset("rnd_rst");
    end
    mid_reset("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
Four-digit decimal (BCD) up/down counter with a built-in time-multiplexed digit scanner. It sits directly upstream of the BCD-to-seven-segment decoder. Each scan slot presents one digit's BCD nibble on bcd_out, together with an active-low one-hot digit select for the display's common pins. One decoder instance and one segment bus serve all four digits.

Parameters:
CLK_DIV_COUNT, 50000000, clk cycles per count tick (1 Hz at 50 MHz); legal range >= 1; 1 = tick every cycle.
SCAN_DIV, 50000, clk cycles per scan slot (1 kHz slot rate at 50 MHz); legal range >= 1.

Ports:
clk        input   1   system clock, all logic rising-edge
rst_n      input   1   asynchronous active-low reset
en         input   1   count enable; 0 = hold value and hold count prescaler
up_dn      input   1   1 = count up, 0 = count down; sampled on the tick cycle
clr        input   1   synchronous clear of value and count prescaler
value      output  16  full BCD count {d3,d2,d1,d0}, d0 = units
bcd_out    output  4   BCD nibble of the digit in the current scan slot
digit_sel  output  4   active-low one-hot digit enable; bit n low = digit n lit
carry      output  1   one-cycle pulse on wrap (9999->0000 up, 0000->9999 down)

Behaviour:
- Reset (rst_n low, asynchronous): value=16'h0000, count prescaler=0, scan prescaler=0, scan index=0, digit_sel=4'b1110, bcd_out=4'h0, carry=0.
- Count prescaler:
  - Counts 0..CLK_DIV_COUNT-1 only while en=1.
  - tick=1 in the cycle it equals CLK_DIV_COUNT-1; wraps to 0 on the next edge.
  - en=0 freezes prescaler and value.
- Count update, on the edge ending the tick cycle:
  - up_dn=1: d0+1. On 9->0, carry into d1, and so on up the digits.
  - up_dn=0: d0-1. On 0->9, borrow from d1, and so on.
  - No digit ever holds A-F.
- carry: registered; high for exactly the one cycle after the wrapping update (value already shows 0000 or 9999).
- clr priority: clr > tick.
  - clr=1 zeroes value and count prescaler on the next edge.
  - carry=0 that cycle, even if the same cycle was a wrapping tick.
  - Scan logic is unaffected by clr.
- Scan:
  - Scan prescaler free-runs 0..SCAN_DIV-1, independent of en and clr.
  - At terminal count, index advances 0->1->2->3->0.
  - digit_sel and bcd_out are registered together from the next index. They change on the same edge, so no slot ever shows a mismatched nibble/select pair.
  - bcd_out always reflects the current value of the selected digit; a count update mid-slot appears on the next edge.
  - Each slot lasts exactly SCAN_DIV cycles.
- Mid-operation reset returns every output to its reset value immediately, without waiting for a clk edge.
- Latency: value changes 1 cycle after the tick cycle; bcd_out follows within 1 cycle.

Decomposition:
- Shared constants in the project include file: BCD_MAX=4'd9, NUM_DIGITS=4, DIGIT_SEL_IDLE=4'b1111.
- Sub-module bcd_digit:
  - one 4-bit cascadable decade counter with inputs inc, dec, clr;
  - outputs digit[3:0], co (wrap 9->0 up), bo (wrap 0->9 down);
  - instantiated 4 times, each stage's co/bo gating the next stage.
- Top level holds both prescalers, the scan index and the output registers.

Test Plan:
(All scenarios run with CLK_DIV_COUNT=1, SCAN_DIV=4.)
1. rst_n low mid-count (value=16'h0527) -> outputs immediately value=0000, digit_sel=1110, bcd_out=0, carry=0.
2. en=1, up_dn=1 from 0000 for 10 cycles -> value=16'h0010; 99 more cycles -> 16'h0109; no carry.
3. Up from 16'h9999, one tick -> value=16'h0000, carry=1 for exactly 1 cycle. Down from 16'h0000, one tick -> value=16'h9999, carry pulse.
4. value held at 16'h1234, en=0 -> repeating sequence, each pair held 4 cycles:
   - (digit_sel=1110, bcd_out=4)
   - (1101, 3)
   - (1011, 2)
   - (0111, 1)
   - No cycle pairs a select with the wrong nibble.
5. clr=1 coincident with wrapping tick at 9999 -> value=0000, carry stays 0. en=0 for 20 cycles -> value unchanged.
6. up_dn toggled every tick from 16'h0005 -> value alternates 0006/0005. Direction is taken from up_dn in the tick cycle.
